pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform and reports its high time, period and integer duty percentage in clock cycles. It is the receive end of the PWM path: it decodes what the clock-divider/PWM generator drives, as well as external RC or encoder PWM lines, for rover motor-feedback and self-test. It has a single clock domain, and `pwm_in` is asynchronous to it.

## Interface
- `CNT_W`, 24: width of the cycle counters and of the `high_cnt`/`period_cnt` outputs.
- `TIMEOUT`, 4_000_000: number of cycles without a rising edge before the input is declared dead. It must satisfy `1 < TIMEOUT < 2^CNT_W`.

- `clk` in 1: system clock (100 MHz).
- `reset` in 1: synchronous, active-high.
- `pwm_in` in 1: PWM input, asynchronous to `clk`.
- `high_cnt` out CNT_W: last measured high time, in cycles.
- `period_cnt` out CNT_W: last measured period, in cycles.
- `duty_pct` out 7: floor(`high_cnt`*100/`period_cnt`), range 0..100.
- `sample_valid` out 1: one-cycle strobe when all three results above update together.
- `no_signal` out 1: level signal, set when no valid sample has been produced or on timeout.

## Operation
- **Input conditioning:** a 2-flop synchronizer, followed by a third register for edge detection.
    - `rise` = sync & ~prev; `fall` = ~sync & prev. Both are registered flags.
    - All three flops reset to 0.
- **Cycle counter `cnt`:**
    - Loads 1 in the cycle where `rise` is high, and otherwise increments.
    - Saturates at `TIMEOUT`.
- **State machine:**
    - IDLE: a `rise` moves to HIGH. A `fall` is ignored. The counter is held at 0.
    - HIGH: on `fall`, latch `hi_lat <= cnt` and move to LOW.
    - LOW: on `rise`, set `per_lat <= cnt` and request a divide, then return to HIGH and begin the next period.
    - A `rise` seen in HIGH (possible only after a missed `fall`) is treated as a period boundary with `hi_lat = per_lat`. This gives a duty of 100; it is a legal sample.
    - Timeout: in HIGH or LOW, when `cnt == TIMEOUT`, go to IDLE.
- **Divider:**
    - Restoring, radix-2, 7 iterations. The dividend is `hi_lat`*100 at CNT_W+7 bits and the divisor is `per_lat`.
    - The quotient always fits in 7 bits because high ≤ period.
    - It runs concurrently with the next measurement.
- **Dropped samples:** a divide request that arrives while the divider is busy is discarded. The outputs stay unchanged and the measurement in progress continues normally.
- **Output update:** on divider completion, load `high_cnt`, `period_cnt` and `duty_pct` in the same cycle, pulse `sample_valid`, and clear `no_signal`.
- **On timeout:**
    - Set `no_signal` to 1 and clear `high_cnt` and `period_cnt` to 0.
    - `duty_pct` becomes 100 if the synchronized input is high, or 0 if it is low.
    - `sample_valid` is not asserted.
    - Any divide in flight is aborted.
- **First edge:** the first `rise` after reset or timeout only starts timing. The first sample comes from the second `rise`.
- **Reset:**
    - Values: all outputs 0 except `no_signal` = 1; state IDLE; counter 0; divider idle.
    - Reset in mid-measurement or mid-divide discards all partial results.

## Timing
- **Edge detection:** a pin transition sampled at clock edge k produces a `rise`/`fall` flag high during cycle k+3, called cycle D.
- **Divider latency:** the divider loads at D+1, iterates D+1..D+7, and the registered outputs and `sample_valid` appear at D+8. Fixed latency is 8 cycles from D.
- **Dropped-sample rule:** periods shorter than 8 cycles complete while the divider is busy, so those samples are dropped.
- **Timeout detection:** `no_signal` rises in the cycle after `cnt` reaches `TIMEOUT`, which is `TIMEOUT` cycles after the last `rise`.
- **Simultaneous events:**
    - Timeout and divider completion in the same cycle: the timeout wins and no `sample_valid` is asserted.
    - Reset has priority over everything.

## Test plan
Bench settings: `CNT_W`=24, `TIMEOUT`=5000.

1. **Steady 25 % wave:** drive a square wave with 250 cycles high and 750 low. From the 2nd rising edge onward, every `sample_valid` shows `high_cnt`=250, `period_cnt`=1000, `duty_pct`=25, and `no_signal`=0. Check that the pulse occurs 8 cycles after D.
2. **First-edge behaviour:** after reset, exactly one rising edge followed by a low level produces no `sample_valid`. `no_signal` stays 1, then outputs remain at 0 after the timeout.
3. **Short period:** 2 cycles high, 3 low, repeated. `sample_valid` fires on every other period (one pulse per 10 cycles) with `high_cnt`=2, `period_cnt`=5, `duty_pct`=40.
4. **Extremes:**
    - 999 high / 1 low gives `duty_pct`=99.
    - 1 high / 999 low gives `duty_pct`=0 with `high_cnt`=1.
5. **Stuck high:** after valid 50 % samples, hold `pwm_in` high. `TIMEOUT` cycles after the last `rise`, `no_signal`=1, `duty_pct`=100, and `high_cnt`=`period_cnt`=0. Restarting the wave clears `no_signal` on the second rising edge's sample.
6. **Reset mid-divide:** assert `reset` at D+4. All outputs return to reset values, no `sample_valid` is asserted, and the next measurement requires two fresh rising edges.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period in clk cycles and derives the
// integer duty percentage with a 7-step restoring divider.
module pwm_capture #(
  parameter int CNT_W   = 24,
  parameter int TIMEOUT = 4_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             sample_valid,
  output logic             no_signal
);

  // state  | meaning
  // IDLE   | no timing reference yet; counter held at 0
  // HIGH   | measuring high phase since last rise
  // LOW    | high time latched, waiting for rise that closes the period
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam int               DW     = CNT_W + 7;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic             r_sync1, r_sync2, r_prev, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_lat;
  logic [CNT_W-1:0] r_per_lat;
  logic [CNT_W-1:0] r_div_hi;
  logic             r_div_busy;
  logic [2:0]       r_div_step;
  logic [DW-1:0]    r_rem;
  logic [DW-1:0]    r_dsh;
  logic [6:0]       r_quo;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_period_cnt;
  logic [6:0]       r_duty_pct;
  logic             r_sample_valid;
  logic             r_no_signal;

  logic             w_timeout;
  logic             w_period_end;
  logic             w_div_start;
  logic [CNT_W-1:0] w_hi_val;
  logic [DW-1:0]    w_dividend;
  logic             w_ge;

  assign high_cnt     = r_high_cnt;
  assign period_cnt   = r_period_cnt;
  assign duty_pct     = r_duty_pct;
  assign sample_valid = r_sample_valid;
  assign no_signal    = r_no_signal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
      r_fall  <= ~r_sync2 & r_prev;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_rise) begin
      r_cnt <= CNT_W'(1);
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt != TO_VAL) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout    = (r_state != S_IDLE) && (r_cnt == TO_VAL);
  assign w_period_end = !w_timeout && r_rise && (r_state != S_IDLE);
  assign w_div_start  = w_period_end && !r_div_busy;
  // A rise while still HIGH means the fall was missed: treat as 100 % duty.
  assign w_hi_val     = (r_state == S_HIGH) ? r_cnt : r_hi_lat;
  assign w_dividend   = {7'd0, w_hi_val} * DW'(100);
  assign w_ge         = (r_rem >= r_dsh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_hi_lat       <= '0;
      r_per_lat      <= '0;
      r_div_hi       <= '0;
      r_div_busy     <= 1'b0;
      r_div_step     <= '0;
      r_rem          <= '0;
      r_dsh          <= '0;
      r_quo          <= '0;
      r_high_cnt     <= '0;
      r_period_cnt   <= '0;
      r_duty_pct     <= '0;
      r_sample_valid <= 1'b0;
      r_no_signal    <= 1'b1;
    end else begin
      r_sample_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_rise) r_state <= S_HIGH;
        end
        S_HIGH: begin
          if (w_timeout) begin
            r_state <= S_IDLE;
          end else if (r_rise) begin
            r_hi_lat <= r_cnt;
          end else if (r_fall) begin
            r_hi_lat <= r_cnt;
            r_state  <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_timeout) begin
            r_state <= S_IDLE;
          end else if (r_rise) begin
            r_state <= S_HIGH;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Timeout overrides both a pending completion and a new divide request.
      if (w_timeout) begin
        r_div_busy   <= 1'b0;
        r_high_cnt   <= '0;
        r_period_cnt <= '0;
        r_duty_pct   <= r_sync2 ? 7'd100 : 7'd0;
        r_no_signal  <= 1'b1;
      end else if (w_div_start) begin
        r_div_busy <= 1'b1;
        r_div_step <= '0;
        r_rem      <= w_dividend;
        r_dsh      <= {1'b0, r_cnt, 6'b0};
        r_quo      <= '0;
        r_div_hi   <= w_hi_val;
        r_per_lat  <= r_cnt;
      end else if (r_div_busy) begin
        r_quo      <= {r_quo[5:0], w_ge};
        r_rem      <= w_ge ? (r_rem - r_dsh) : r_rem;
        r_dsh      <= r_dsh >> 1;
        r_div_step <= r_div_step + 3'd1;
        if (r_div_step == 3'd6) begin
          r_div_busy     <= 1'b0;
          r_high_cnt     <= r_div_hi;
          r_period_cnt   <= r_per_lat;
          r_duty_pct     <= {r_quo[5:0], w_ge};
          r_sample_valid <= 1'b1;
          r_no_signal    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM patterns on the falling clock
// edge and checks every result strobe against hand-computed values.
module tb_pwm_capture;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 5000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [6:0]       duty_pct;
  logic             sample_valid;
  logic             no_signal;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .high_cnt     (high_cnt),
    .period_cnt   (period_cnt),
    .duty_pct     (duty_pct),
    .sample_valid (sample_valid),
    .no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_hi, exp_per, exp_duty;
  bit chk_en = 0, sv_forbid = 0, lat_chk = 0, spc_chk = 0;
  int last_rise = 0, last_pulse = 0, pulses = 0, t_rise = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock cycle; outputs are sampled mid-cycle on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (sv_forbid) chk("no_pulse", sample_valid, 0);
    if (chk_en && sample_valid) begin
      pulses++;
      chk("high_cnt", high_cnt, exp_hi);
      chk("period_cnt", period_cnt, exp_per);
      chk("duty_pct", duty_pct, exp_duty);
      chk("no_signal_on_sample", no_signal, 0);
      if (lat_chk) chk("latency", cyc - last_rise, 11);
      if (spc_chk && pulses > 1) chk("spacing", cyc - last_pulse, 10);
      last_pulse = cyc;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      pwm_in = 1'b1;
      last_rise = cyc;
      for (int i = 0; i < h; i++) step();
      pwm_in = 1'b0;
      for (int i = 0; i < l; i++) step();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_duty"}, duty_pct, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_nosig"}, no_signal, 1);
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    reset  = 1'b1;
    repeat (3) step();
    chk_reset_vals("rst");
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // First edge only starts timing, then the line dies.
    do_reset();
    sv_forbid = 1;
    pwm_in = 1'b1;
    repeat (10) step();
    pwm_in = 1'b0;
    repeat (100) step();
    chk("first_edge_nosig", no_signal, 1);
    repeat (TIMEOUT) step();
    chk("first_to_nosig", no_signal, 1);
    chk("first_to_high", high_cnt, 0);
    chk("first_to_period", period_cnt, 0);
    chk("first_to_duty", duty_pct, 0);
    sv_forbid = 0;

    // Steady 25 % wave with latency check.
    do_reset();
    exp_hi = 250; exp_per = 1000; exp_duty = 25;
    chk_en = 1; lat_chk = 1; pulses = 0;
    wave(250, 750, 5);
    chk("t25_pulses", pulses, 4);
    chk("t25_nosig", no_signal, 0);
    chk("t25_duty_hold", duty_pct, 25);
    chk_en = 0; lat_chk = 0;

    // Short period: every other sample dropped while divider busy.
    do_reset();
    exp_hi = 2; exp_per = 5; exp_duty = 40;
    chk_en = 1; spc_chk = 1; pulses = 0;
    wave(2, 3, 20);
    repeat (20) step();
    chk("short_pulses", pulses, 10);
    chk_en = 0; spc_chk = 0;

    // Extremes.
    do_reset();
    exp_hi = 999; exp_per = 1000; exp_duty = 99;
    chk_en = 1; pulses = 0;
    wave(999, 1, 3);
    chk("d99_pulses", pulses, 2);
    chk_en = 0;

    do_reset();
    exp_hi = 1; exp_per = 1000; exp_duty = 0;
    chk_en = 1; pulses = 0;
    wave(1, 999, 3);
    chk("d0_pulses", pulses, 2);
    chk_en = 0;

    // Stuck high after 50 % samples, then restart.
    do_reset();
    exp_hi = 500; exp_per = 1000; exp_duty = 50;
    chk_en = 1; pulses = 0;
    wave(500, 500, 3);
    pwm_in = 1'b1;
    t_rise = cyc;
    while (cyc < t_rise + 5003) step();
    chk("stuck_pulses", pulses, 3);
    chk("stuck_pre_nosig", no_signal, 0);
    step();
    chk("stuck_nosig", no_signal, 1);
    chk("stuck_duty", duty_pct, 100);
    chk("stuck_high", high_cnt, 0);
    chk("stuck_period", period_cnt, 0);
    pwm_in = 1'b0;
    pulses = 0;
    repeat (500) step();
    wave(500, 500, 1);
    chk("restart_first_nosig", no_signal, 1);
    chk("restart_first_pulses", pulses, 0);
    wave(500, 500, 2);
    chk("restart_pulses", pulses, 2);
    chk("restart_nosig", no_signal, 0);
    chk_en = 0;

    // Reset in the middle of a divide.
    do_reset();
    pwm_in = 1'b1;
    repeat (100) step();
    pwm_in = 1'b0;
    repeat (100) step();
    pwm_in = 1'b1;
    repeat (7) step();
    reset = 1'b1;
    pwm_in = 1'b0;
    sv_forbid = 1;
    repeat (2) step();
    chk_reset_vals("middiv_rst");
    reset = 1'b0;
    repeat (20) step();
    chk_reset_vals("middiv_after");
    sv_forbid = 0;
    exp_hi = 100; exp_per = 200; exp_duty = 50;
    chk_en = 1; lat_chk = 1; pulses = 0;
    wave(100, 100, 2);
    chk("middiv_pulses", pulses, 1);
    chk_en = 0; lat_chk = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
